// File: rtl/d_transfer_pkg.sv
// rtl/d_transfer_pkg.sv - shared types and encodings for the D-format transfer sequencer
package d_transfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [4:0] FSEL_ADD  = 5'b01000;
  localparam logic [1:0] DSEL_ALU  = 2'b00;
  localparam logic [1:0] DSEL_RAM  = 2'b01;
  localparam logic [1:0] PSEL_HOLD = 2'b00;
  localparam logic [1:0] PSEL_INC  = 2'b01;

  localparam logic [1:0] OP2_UNSCALED = 2'b00;
  localparam logic [1:0] OP2_POST     = 2'b01;
  localparam logic [1:0] OP2_BAD      = 2'b10;
  localparam logic [1:0] OP2_PRE      = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Non-register fields of the control word; register addresses are packed in by the top.
  typedef struct packed {
    logic [1:0] psel;
    logic [4:0] fsel;
    logic       regw;
    logic       ramw;
    logic [1:0] dsel;
    logic       bsel;
    logic       pcsel;
    logic       sl;
  } cw_ctrl_t;

  localparam cw_ctrl_t CW_CTRL_NOP = '0;

  function automatic int cw_width(input int reg_bits);
    return 3 * reg_bits + 14;
  endfunction

endpackage

// File: rtl/d_transfer_decode.sv
// rtl/d_transfer_decode.sv - combinational field extraction, imm9 sign extension and legality check
module d_transfer_decode
  import d_transfer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_BITS   = 5
) (
  input  logic [31:0]           i_instruction,
  output logic [1:0]            o_size,
  output logic                  o_is_load,
  output logic                  o_has_wb,
  output logic                  o_post,
  output logic [REG_BITS-1:0]   o_rn,
  output logic [REG_BITS-1:0]   o_rt,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic                  o_illegal
);

  logic [8:0] w_imm9;
  logic [1:0] w_op2;
  logic [4:0] w_rn_raw;
  logic [4:0] w_rt_raw;
  logic       w_unused;

  assign w_imm9   = i_instruction[20:12];
  assign w_op2    = i_instruction[11:10];
  assign w_rn_raw = i_instruction[9:5];
  assign w_rt_raw = i_instruction[4:0];
  assign w_unused = ^{i_instruction[29:23], i_instruction[21]};

  assign o_size    = i_instruction[31:30];
  assign o_is_load = i_instruction[22];
  assign o_rn      = REG_BITS'(w_rn_raw);
  assign o_rt      = REG_BITS'(w_rt_raw);
  assign o_imm     = {{(DATA_WIDTH-9){w_imm9[8]}}, w_imm9};
  assign o_post    = (w_op2 == OP2_POST);
  assign o_has_wb  = (w_op2 == OP2_POST) || (w_op2 == OP2_PRE);

  // A writeback load with Rn==Rt would have two results targeting one register.
  assign o_illegal = (w_op2 == OP2_BAD) ||
                     (o_is_load && o_has_wb && (w_rn_raw == w_rt_raw));

endmodule

// File: rtl/d_transfer_seq.sv
// rtl/d_transfer_seq.sv - ADDR/MEM/WB sequencer emitting one datapath control word per cycle
module d_transfer_seq
  import d_transfer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_BITS   = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               instruction,
  input  logic                      mem_ready,
  output logic [3*REG_BITS+13:0]    controlWord,
  output logic [DATA_WIDTH-1:0]     K,
  output logic                      mem_req,
  output logic [1:0]                size,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_instr;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                r_done;
  logic                r_err;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_accept;

  logic [31:0]           w_dec_instr;
  logic [1:0]            w_size;
  logic                  w_is_load;
  logic                  w_has_wb;
  logic                  w_post;
  logic [REG_BITS-1:0]   w_rn;
  logic [REG_BITS-1:0]   w_rt;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_illegal;

  cw_ctrl_t              w_ctrl;
  logic [REG_BITS-1:0]   w_da;
  logic [REG_BITS-1:0]   w_sa;
  logic [REG_BITS-1:0]   w_sb;
  logic [DATA_WIDTH-1:0] w_k;
  logic                  w_mem_req;

  // In IDLE the decoder looks at the incoming instruction for the legality check;
  // once busy it decodes the latched copy.
  assign w_dec_instr = (r_state == IDLE) ? instruction : r_instr;

  d_transfer_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_BITS   (REG_BITS)
  ) u_decode (
    .i_instruction (w_dec_instr),
    .o_size        (w_size),
    .o_is_load     (w_is_load),
    .o_has_wb      (w_has_wb),
    .o_post        (w_post),
    .o_rn          (w_rn),
    .o_rt          (w_rt),
    .o_imm         (w_imm),
    .o_illegal     (w_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_wait  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_instr <= instruction;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_ctrl      = CW_CTRL_NOP;
    w_da        = '0;
    w_sa        = '0;
    w_sb        = '0;
    w_k         = '0;
    w_mem_req   = 1'b0;

    case (r_state)
      IDLE: begin
        w_wait_nxt = '0;
        if (start) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ADDR;
          end
        end
      end

      ADDR: begin
        w_sa        = w_rn;
        w_ctrl.fsel = FSEL_ADD;
        w_ctrl.bsel = 1'b1;
        w_ctrl.dsel = DSEL_ALU;
        w_k         = w_post ? '0 : w_imm;
        w_state_nxt = MEM;
      end

      MEM: begin
        w_sa        = w_rn;
        w_sb        = w_rt;
        w_ctrl.fsel = FSEL_ADD;
        w_ctrl.bsel = 1'b1;
        w_ctrl.dsel = DSEL_ALU;
        w_k         = w_post ? '0 : w_imm;
        w_mem_req   = 1'b1;
        if (mem_ready) begin
          w_wait_nxt = '0;
          if (w_is_load) begin
            w_da        = w_rt;
            w_ctrl.dsel = DSEL_RAM;
            w_ctrl.regw = (w_rt != {REG_BITS{1'b1}});
          end else begin
            w_ctrl.ramw = 1'b1;
          end
          // PC advances in the last active cycle, which is WB when writeback follows.
          if (w_has_wb) begin
            w_state_nxt = WB;
          end else begin
            w_ctrl.psel = PSEL_INC;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_wait_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      WB: begin
        w_da        = w_rn;
        w_sa        = w_rn;
        w_k         = w_imm;
        w_ctrl.fsel = FSEL_ADD;
        w_ctrl.bsel = 1'b1;
        w_ctrl.dsel = DSEL_ALU;
        w_ctrl.regw = 1'b1;
        w_ctrl.psel = PSEL_INC;
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign controlWord = {w_ctrl.psel, w_da, w_sa, w_sb, w_ctrl.fsel, w_ctrl.regw,
                        w_ctrl.ramw, w_ctrl.dsel, w_ctrl.bsel, w_ctrl.pcsel, w_ctrl.sl};
  assign K       = w_k;
  assign mem_req = w_mem_req;
  assign busy    = (r_state != IDLE);
  assign size    = busy ? w_size : SIZE_B;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_d_transfer_seq.sv
// tb/tb_d_transfer_seq.sv - directed table-driven bench for d_transfer_seq
module tb_d_transfer_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic        mem_ready;
  logic [28:0] controlWord;
  logic [63:0] K;
  logic        mem_req;
  logic [1:0]  size;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;

  localparam logic [4:0] ADD = 5'b01000;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          waits;
    bit          illegal;
    bit          wb;
    logic [1:0]  sz;
    logic [63:0] k_addr;
    logic [63:0] k_wb;
    logic [28:0] cw_addr;
    logic [28:0] cw_wait;
    logic [28:0] cw_ready;
    logic [28:0] cw_wb;
  } vec_t;

  vec_t vecs[9];

  d_transfer_seq dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .mem_ready   (mem_ready),
    .controlWord (controlWord),
    .K           (K),
    .mem_req     (mem_req),
    .size        (size),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [1:0] sz, input logic ld, input logic [8:0] imm,
                                     input logic [1:0] op2, input logic [4:0] rn, input logic [4:0] rt);
    return {sz, 7'b0, ld, 1'b0, imm, op2, rn, rt};
  endfunction

  function automatic logic [28:0] pc(input logic [1:0] psel, input logic [4:0] da, input logic [4:0] sa,
                                     input logic [4:0] sb, input logic [4:0] fsel, input logic regw,
                                     input logic ramw, input logic [1:0] dsel, input logic bsel);
    return {psel, da, sa, sb, fsel, regw, ramw, dsel, bsel, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " cw"},   64'(controlWord), 64'h0);
    chk({nm, " K"},    K, 64'h0);
    chk({nm, " busy"}, 64'(busy), 64'h0);
    chk({nm, " req"},  64'(mem_req), 64'h0);
    chk({nm, " size"}, 64'(size), 64'h0);
  endtask

  task automatic run_vec(input vec_t v);
    tick();
    start = 1'b1;
    instruction = v.instr;
    mem_ready = 1'b0;
    @(negedge clock);
    chk({v.name, " pre busy"}, 64'(busy), 64'h0);
    chk({v.name, " pre done"}, 64'(done), 64'h0);
    tick();
    start = 1'b0;
    instruction = 32'h0;
    if (v.illegal) begin
      @(negedge clock);
      chk({v.name, " err"},  64'(err), 64'h1);
      chk({v.name, " done"}, 64'(done), 64'h0);
      chk_idle(v.name);
      tick();
      @(negedge clock);
      chk({v.name, " err drop"}, 64'(err), 64'h0);
      chk({v.name, " stay idle"}, 64'(busy), 64'h0);
    end else begin
      @(negedge clock);
      chk({v.name, " addr cw"},   64'(controlWord), 64'(v.cw_addr));
      chk({v.name, " addr K"},    K, v.k_addr);
      chk({v.name, " addr busy"}, 64'(busy), 64'h1);
      chk({v.name, " addr req"},  64'(mem_req), 64'h0);
      chk({v.name, " size"},      64'(size), 64'(v.sz));
      for (int w = 0; w <= v.waits; w++) begin
        tick();
        mem_ready = (w == v.waits);
        @(negedge clock);
        if (w == v.waits) chk({v.name, " ready cw"}, 64'(controlWord), 64'(v.cw_ready));
        else              chk({v.name, " wait cw"},  64'(controlWord), 64'(v.cw_wait));
        chk({v.name, " mem req"}, 64'(mem_req), 64'h1);
        chk({v.name, " mem K"},   K, v.k_addr);
      end
      tick();
      mem_ready = 1'b0;
      if (v.wb) begin
        @(negedge clock);
        chk({v.name, " wb cw"}, 64'(controlWord), 64'(v.cw_wb));
        chk({v.name, " wb K"},  K, v.k_wb);
        chk({v.name, " wb done early"}, 64'(done), 64'h0);
        tick();
      end
      @(negedge clock);
      chk({v.name, " done"}, 64'(done), 64'h1);
      chk({v.name, " err"},  64'(err), 64'h0);
      chk_idle({v.name, " end"});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    instruction = 32'h0;
    mem_ready = 1'b0;

    vecs[0] = '{"stur_x1", mk(2'b11, 1'b0, 9'd8, 2'b00, 5'd2, 5'd1), 0, 0, 0, 2'b11,
                64'd8, 64'd0,
                pc(2'b00, 5'd0, 5'd2, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd2, 5'd1, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b01, 5'd0, 5'd2, 5'd1, ADD, 1'b0, 1'b1, 2'b00, 1'b1), 29'h0};
    vecs[1] = '{"ldur_w3", mk(2'b10, 1'b1, 9'h1FC, 2'b00, 5'd4, 5'd3), 2, 0, 0, 2'b10,
                64'hFFFF_FFFF_FFFF_FFFC, 64'd0,
                pc(2'b00, 5'd0, 5'd4, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd4, 5'd3, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b01, 5'd3, 5'd4, 5'd3, ADD, 1'b1, 1'b0, 2'b01, 1'b1), 29'h0};
    vecs[2] = '{"ldr_post", mk(2'b11, 1'b1, 9'd16, 2'b01, 5'd6, 5'd5), 0, 0, 1, 2'b11,
                64'd0, 64'd16,
                pc(2'b00, 5'd0, 5'd6, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd6, 5'd5, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd5, 5'd6, 5'd5, ADD, 1'b1, 1'b0, 2'b01, 1'b1),
                pc(2'b01, 5'd6, 5'd6, 5'd0, ADD, 1'b1, 1'b0, 2'b00, 1'b1)};
    vecs[3] = '{"str_pre", mk(2'b11, 1'b0, 9'h1F0, 2'b11, 5'd9, 5'd8), 1, 0, 1, 2'b11,
                64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0,
                pc(2'b00, 5'd0, 5'd9, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd9, 5'd8, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd9, 5'd8, ADD, 1'b0, 1'b1, 2'b00, 1'b1),
                pc(2'b01, 5'd9, 5'd9, 5'd0, ADD, 1'b1, 1'b0, 2'b00, 1'b1)};
    vecs[4] = '{"ldurb_xzr", mk(2'b00, 1'b1, 9'd0, 2'b00, 5'd1, 5'd31), 0, 0, 0, 2'b00,
                64'd0, 64'd0,
                pc(2'b00, 5'd0, 5'd1, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd1, 5'd31, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b01, 5'd31, 5'd1, 5'd31, ADD, 1'b0, 1'b0, 2'b01, 1'b1), 29'h0};
    vecs[5] = '{"sturh_post_same", mk(2'b01, 1'b0, 9'd4, 2'b01, 5'd3, 5'd3), 0, 0, 1, 2'b01,
                64'd0, 64'd4,
                pc(2'b00, 5'd0, 5'd3, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd3, 5'd3, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd3, 5'd3, ADD, 1'b0, 1'b1, 2'b00, 1'b1),
                pc(2'b01, 5'd3, 5'd3, 5'd0, ADD, 1'b1, 1'b0, 2'b00, 1'b1)};
    vecs[6] = '{"ill_op2", mk(2'b11, 1'b1, 9'd8, 2'b10, 5'd2, 5'd1), 0, 1, 0, 2'b00,
                64'd0, 64'd0, 29'h0, 29'h0, 29'h0, 29'h0};
    vecs[7] = '{"ill_ldr_x7", mk(2'b11, 1'b1, 9'd8, 2'b11, 5'd7, 5'd7), 0, 1, 0, 2'b00,
                64'd0, 64'd0, 29'h0, 29'h0, 29'h0, 29'h0};
    vecs[8] = '{"ldr_pre_255", mk(2'b11, 1'b1, 9'h0FF, 2'b11, 5'd11, 5'd10), 0, 0, 1, 2'b11,
                64'd255, 64'd255,
                pc(2'b00, 5'd0, 5'd11, 5'd0, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd0, 5'd11, 5'd10, ADD, 1'b0, 1'b0, 2'b00, 1'b1),
                pc(2'b00, 5'd10, 5'd11, 5'd10, ADD, 1'b1, 1'b0, 2'b01, 1'b1),
                pc(2'b01, 5'd11, 5'd11, 5'd0, ADD, 1'b1, 1'b0, 2'b00, 1'b1)};

    // Reset state, with start asserted to show it has no effect during reset.
    tick();
    start = 1'b1;
    instruction = vecs[0].instr;
    tick();
    @(negedge clock);
    chk_idle("reset");
    chk("reset done", 64'(done), 64'h0);
    chk("reset err",  64'(err), 64'h0);
    tick();
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Timeout: mem_ready never arrives.
    tick();
    start = 1'b1;
    instruction = vecs[1].instr;
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("to addr cw", 64'(controlWord), 64'(vecs[1].cw_addr));
    for (int c = 0; c < 15; c++) begin
      tick();
      @(negedge clock);
      chk("to wait cw", 64'(controlWord), 64'(vecs[1].cw_wait));
      chk("to wait req", 64'(mem_req), 64'h1);
      chk("to no err yet", 64'(err), 64'h0);
    end
    tick();
    @(negedge clock);
    chk("to err", 64'(err), 64'h1);
    chk("to done", 64'(done), 64'h0);
    chk_idle("to end");
    tick();
    @(negedge clock);
    chk("to err drop", 64'(err), 64'h0);

    // Start while busy is ignored, then reset aborts in MEM.
    tick();
    start = 1'b1;
    instruction = vecs[0].instr;
    tick();
    instruction = vecs[6].instr;
    @(negedge clock);
    chk("busy addr cw", 64'(controlWord), 64'(vecs[0].cw_addr));
    tick();
    start = 1'b0;
    instruction = 32'h0;
    @(negedge clock);
    chk("busy mem cw", 64'(controlWord), 64'(vecs[0].cw_wait));
    chk("busy no err", 64'(err), 64'h0);
    chk("busy mem req", 64'(mem_req), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_idle("abort");
    chk("abort done", 64'(done), 64'h0);
    chk("abort err",  64'(err), 64'h0);
    tick();
    @(negedge clock);
    chk_idle("abort after");
    chk("abort after done", 64'(done), 64'h0);

    // Normal operation resumes after the abort.
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
